// File: rtl/arb_req_queue.sv
// Per-requestor ingress FIFOs feeding a round-robin arbiter; the granted head
// word is popped into a single registered valid/ready output slot.
module arb_req_queue #(
    parameter int REQ_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [REQ_WIDTH-1:0]                   in_valid,
    output logic [REQ_WIDTH-1:0]                   in_ready,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0]        in_data,
    output logic [REQ_WIDTH-1:0]                   req,
    input  logic [REQ_WIDTH-1:0]                   gnt,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [$clog2(REQ_WIDTH)-1:0]           out_src,
    output logic [REQ_WIDTH*($clog2(DEPTH)+1)-1:0] occupancy
);
    localparam int SRC_W = $clog2(REQ_WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem  [REQ_WIDTH][DEPTH];
    logic [PTR_W-1:0]      r_wptr [REQ_WIDTH];
    logic [PTR_W-1:0]      r_rptr [REQ_WIDTH];
    logic [CNT_W-1:0]      r_cnt  [REQ_WIDTH];

    logic                  r_vld_p1;
    logic [DATA_WIDTH-1:0] r_data_p1;
    logic [SRC_W-1:0]      r_src_p1;

    logic                  w_load_ok;
    logic [REQ_WIDTH-1:0]  w_push;
    logic [REQ_WIDTH-1:0]  w_cand;
    logic [REQ_WIDTH-1:0]  w_pop;
    logic [SRC_W-1:0]      w_sel_idx;
    logic [DATA_WIDTH-1:0] w_head;

    // Requests drop while the output slot is blocked, so an ungranted-but-
    // unconsumed grant never advances the arbiter's round-robin pointer.
    always_comb begin
        w_load_ok = !r_vld_p1 || out_ready;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            in_ready[i] = !reset && (r_cnt[i] != FULL);
            req[i]      = !reset && (r_cnt[i] != '0) && w_load_ok;
        end
    end

    assign w_push = in_valid & in_ready;
    assign w_cand = gnt & req;
    assign w_pop  = w_cand & (~w_cand + REQ_WIDTH'(1));

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (w_pop[i]) begin
                w_sel_idx = SRC_W'(i);
            end
        end
    end

    assign w_head = r_mem[w_sel_idx][r_rptr[w_sel_idx]];

    // ---- stage p0: FIFO storage (data only, no reset) ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_src_p1  <= '0;
        end else begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_pop[i] && !w_push[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
            // ---- stage p1: output slot ----
            if (|w_pop) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_head;
                r_src_p1  <= w_sel_idx;
            end else if (out_ready) begin
                r_vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_src   = r_src_p1;

    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_occ
        assign occupancy[g*CNT_W +: CNT_W] = r_cnt[g];

        a_no_overflow: assert property (@(posedge clk) disable iff (reset)
            !(w_push[g] && !w_pop[g] && r_cnt[g] == FULL));
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            !(w_pop[g] && !w_push[g] && r_cnt[g] == '0));
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

endmodule

// File: tb/tb_arb_req_queue.sv
// Randomized and directed bench for arb_req_queue against a queue-based
// reference model, with a small round-robin arbiter driving gnt.
module tb_arb_req_queue;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic [11:0]   occupancy;

    arb_req_queue #(.REQ_WIDTH(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req(req), .gnt(gnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter, or a forced grant vector when arb_mode=1
    logic         arb_mode;
    logic [N-1:0] force_gnt;
    logic [N-1:0] arb_rr_gnt;
    int           arb_last;

    always_comb begin
        arb_rr_gnt = '0;
        for (int k = 1; k <= N; k++) begin
            if (arb_rr_gnt == '0 && req[(arb_last + k) % N]) begin
                arb_rr_gnt[(arb_last + k) % N] = 1'b1;
            end
        end
    end

    assign gnt = arb_mode ? force_gnt : arb_rr_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_last <= N - 1;
        end else if (!arb_mode) begin
            for (int k = 0; k < N; k++) begin
                if (arb_rr_gnt[k]) arb_last <= k;
            end
        end
    end

    // Reference model state
    logic [DW-1:0] q [N][$];
    logic          ev;
    logic [DW-1:0] ed;
    logic [1:0]    es;
    logic [33:0]   acc [$];
    int            acc_cyc [$];
    int            cyc;

    logic [N-1:0]  s_req, s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_out_src;
    logic [11:0]   s_occ;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy, exp_req, cand, pushv;
        logic         lok;
        int           sel;
        @(negedge clk);
        lok = !ev || out_ready;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !reset && (q[i].size() < D);
            exp_req[i] = !reset && (q[i].size() != 0) && lok;
        end
        s_req = req; s_in_ready = in_ready; s_out_valid = out_valid;
        s_out_data = out_data; s_out_src = out_src; s_occ = occupancy;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("req", 64'(req), 64'(exp_req));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_data", 64'(out_data), 64'(ed));
        chk("out_src", 64'(out_src), 64'(es));
        for (int i = 0; i < N; i++) begin
            chk("occupancy", 64'(occupancy[i*3 +: 3]), 64'(q[i].size()));
        end
        if (out_valid && out_ready && !reset) begin
            acc.push_back({out_src, out_data});
            acc_cyc.push_back(cyc);
        end
        if (reset) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ev = 1'b0; ed = '0; es = '0;
        end else begin
            for (int i = 0; i < N; i++) pushv[i] = in_valid[i] && exp_rdy[i];
            cand = gnt & exp_req;
            sel = -1;
            for (int i = 0; i < N; i++) if (cand[i] && sel < 0) sel = i;
            if (sel >= 0) begin
                ed = q[sel].pop_front();
                es = 2'(sel);
                ev = 1'b1;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            for (int i = 0; i < N; i++) if (pushv[i]) q[i].push_back(in_data[i*DW +: DW]);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; in_valid = '0;
        for (int k = 0; k < n; k++) cycle();
        reset = 1'b0;
    endtask

    task automatic load_all(input logic [N-1:0] chans);
        arb_mode = 1'b1; force_gnt = '0; out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_valid = chans;
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'(32'h100 * i + n);
            cycle();
        end
        in_valid = '0;
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        arb_mode = 1'b1; force_gnt = '0;
        ev = 1'b0; ed = '0; es = '0; cyc = 0;
        @(posedge clk); #1;

        // Reset then idle
        do_reset(2);
        cycle();
        chk("idle_out_valid", 64'(s_out_valid), 64'd0);
        chk("idle_req", 64'(s_req), 64'd0);
        chk("idle_in_ready", 64'(s_in_ready), 64'hF);
        chk("idle_occ", 64'(s_occ), 64'd0);

        // Single push on ch2 with forced grant
        force_gnt = 4'b0100; out_ready = 1'b1;
        in_valid = 4'b0100; in_data[2*DW +: DW] = 32'hA5A5_0002;
        cycle();
        in_valid = '0;
        cycle();
        chk("ch2_req", 64'(s_req), 64'h4);
        cycle();
        chk("ch2_valid", 64'(s_out_valid), 64'd1);
        chk("ch2_data", 64'(s_out_data), 64'hA5A5_0002);
        chk("ch2_src", 64'(s_out_src), 64'd2);
        chk("ch2_occ", 64'(s_occ[8:6]), 64'd0);

        // Fill and backpressure on ch0
        do_reset(1);
        arb_mode = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b0001; in_data[0 +: DW] = 32'hC0DE_0000 + 32'(k);
            cycle();
        end
        in_valid = 4'b0001;
        cycle();
        in_valid = '0;
        chk("fill_in_ready0", 64'(s_in_ready[0]), 64'd0);
        chk("fill_occ0", 64'(s_occ[2:0]), 64'd4);
        chk("fill_req0", 64'(s_req[0]), 64'd0);
        chk("fill_data", 64'(s_out_data), 64'hC0DE_0000);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        // Round-robin drain
        do_reset(1);
        load_all(4'b1111);
        arb_mode = 1'b0; out_ready = 1'b1;
        acc.delete(); acc_cyc.delete();
        for (int k = 0; k < 11; k++) cycle();
        chk("rr_count", 64'(acc.size()), 64'd8);
        for (int k = 0; k < 8 && k < acc.size(); k++) begin
            chk("rr_word", 64'(acc[k]), {30'd0, 2'(k % 4), 32'(32'h100 * (k % 4) + k / 4)});
            chk("rr_nogap", 64'(acc_cyc[k]), 64'(acc_cyc[0] + k));
        end

        // Bubble stall with ch1 and ch3
        do_reset(1);
        load_all(4'b1010);
        arb_mode = 1'b0;
        acc.delete(); acc_cyc.delete();
        for (int t = 0; t < 12; t++) begin
            out_ready = (t < 8) ? ((t % 2) == 0) : 1'b1;
            cycle();
        end
        chk("bub_count", 64'(acc.size()), 64'd4);
        if (acc.size() == 4) begin
            chk("bub_w0", 64'(acc[0]), {30'd0, 2'd1, 32'h100});
            chk("bub_w1", 64'(acc[1]), {30'd0, 2'd3, 32'h300});
            chk("bub_w2", 64'(acc[2]), {30'd0, 2'd1, 32'h101});
            chk("bub_w3", 64'(acc[3]), {30'd0, 2'd3, 32'h301});
        end

        // Mid-stream reset
        do_reset(1);
        load_all(4'b1111);
        arb_mode = 1'b0; out_ready = 1'b0;
        cycle();
        out_ready = 1'b1;
        do_reset(1);
        cycle();
        chk("mrst_valid", 64'(s_out_valid), 64'd0);
        chk("mrst_occ", 64'(s_occ), 64'd0);
        chk("mrst_in_ready", 64'(s_in_ready), 64'hF);
        acc.delete(); acc_cyc.delete();
        for (int k = 0; k < 10; k++) cycle();
        chk("mrst_no_stale", 64'(acc.size()), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            in_valid = 4'($urandom);
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            arb_mode = 1'($urandom);
            force_gnt = ($urandom_range(0, 4) == 4) ? 4'b0 : 4'(1 << $urandom_range(0, 3));
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
